// File: rtl/entropy_byte_collector.sv
// Entropy byte collector: samples the raw TRNG bit stream, runs a
// repetition-count health test, removes bias with a von Neumann
// corrector and packs corrected bits into WIDTH-bit words.
// Handshake: a word is transferred on a clk edge where byte_valid=1 and
// byte_ready=1; byte_data is held stable while byte_valid=1 and
// byte_ready=0.
module entropy_byte_collector #(
   parameter int REP_LIMIT = 16,
   parameter int WIDTH     = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ena,
   input  logic             raw_bit,
   output logic [WIDTH-1:0] byte_data,
   output logic             byte_valid,
   input  logic             byte_ready,
   output logic             health_fail,
   output logic [7:0]       overrun_cnt,
   output logic [1:0]       dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_FIRST  = 2'd1,
      S_SECOND = 2'd2,
      S_FAIL   = 2'd3
   } state_t;

   localparam int              CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [7:0]       LIMIT    = 8'(REP_LIMIT);

   state_t           state_q;
   logic             pair_q;
   logic             prev_q;
   logic             ref_ok_q;
   logic [7:0]       run_q;
   logic [WIDTH-1:0] shift_q;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] data_q;
   logic             valid_q;
   logic             fail_q;
   logic [7:0]       ovr_q;

   logic             sample;
   logic [7:0]       run_d;
   logic             trip;
   logic             emit;
   logic             done;
   logic [WIDTH-1:0] word_d;

   // Next run count, health-test trip and corrector/packer decisions.
   always_comb begin
      sample = ena && ((state_q == S_FIRST) || (state_q == S_SECOND));
      run_d  = 8'd1;
      if (ref_ok_q && (raw_bit == prev_q)) begin
         run_d = (run_q >= LIMIT) ? LIMIT : run_q + 8'd1;
      end
      trip   = sample && (run_d == LIMIT);
      emit   = ena && (state_q == S_SECOND) && (raw_bit != pair_q) && !trip;
      done   = emit && (cnt_q == CNT_LAST);
      word_d = {shift_q[WIDTH-2:0], pair_q};
   end

   // Sampling FSM with repetition-count tracking; FAIL is sticky until rst.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         pair_q   <= 1'b0;
         prev_q   <= 1'b0;
         ref_ok_q <= 1'b0;
         run_q    <= 8'd0;
         fail_q   <= 1'b0;
      end else begin
         case (state_q)
            S_FAIL: state_q <= S_FAIL;
            default: begin
               if (!ena) begin
                  // Dropping out discards any half pair and breaks the run.
                  state_q  <= S_IDLE;
                  ref_ok_q <= 1'b0;
               end else if (state_q == S_IDLE) begin
                  state_q <= S_FIRST;
               end else begin
                  run_q    <= run_d;
                  prev_q   <= raw_bit;
                  ref_ok_q <= 1'b1;
                  if (trip) begin
                     state_q <= S_FAIL;
                     fail_q  <= 1'b1;
                  end else if (state_q == S_FIRST) begin
                     pair_q  <= raw_bit;
                     state_q <= S_SECOND;
                  end else begin
                     state_q <= S_FIRST;
                  end
               end
            end
         endcase
      end
   end

   // Packing shift register and output word register with overrun count.
   always_ff @(posedge clk) begin
      if (rst) begin
         shift_q <= '0;
         cnt_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 8'd0;
      end else if (state_q == S_FAIL) begin
         valid_q <= 1'b0;
      end else if (trip) begin
         // Health failure flushes any pending word and partial bits.
         valid_q <= 1'b0;
         shift_q <= '0;
         cnt_q   <= '0;
      end else begin
         if (emit) begin
            shift_q <= word_d;
            cnt_q   <= done ? '0 : cnt_q + 1'b1;
         end
         if (done) begin
            if (!valid_q || byte_ready) begin
               data_q  <= word_d;
               valid_q <= 1'b1;
            end else if (ovr_q != 8'hFF) begin
               ovr_q <= ovr_q + 8'd1;
            end
         end else if (valid_q && byte_ready) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign byte_data   = data_q;
   assign byte_valid  = valid_q;
   assign health_fail = fail_q;
   assign overrun_cnt = ovr_q;
   assign dbg_state   = state_q;

endmodule
